axis_fifo_sync: RTL and testbench
=================================

Name: axis_fifo_sync

Overview:
- Single-clock AXI4-Stream FIFO that buffers beats ahead of the pass-through stream join stage in the example-master datapath.
- Absorbs backpressure bursts from the downstream consumer.
- Provides a fill-level output for flow-control monitoring.
- Carries the same tdata/tstrb/tlast sideband as the downstream join stage; no tuser.

Parameters:
- AXIS_DATA_WIDTH, 32, tdata width in bits; multiple of 8; tstrb width is AXIS_DATA_WIDTH/8.
- FIFO_DEPTH, 16, number of beat entries; power of two, minimum 2.

Ports:
- aclk  input  1  single clock; all state updates on rising edge.
- areset  input  1  asynchronous, active-high reset.
- s_tvalid  input  1  upstream beat valid.
- s_tready  output  1  FIFO can accept a beat.
- s_tdata  input  AXIS_DATA_WIDTH  upstream data.
- s_tstrb  input  AXIS_DATA_WIDTH/8  upstream byte strobes.
- s_tlast  input  1  upstream end of packet.
- m_tvalid  output  1  head beat valid.
- m_tready  input  1  downstream accepts head beat.
- m_tdata  output  AXIS_DATA_WIDTH  head data.
- m_tstrb  output  AXIS_DATA_WIDTH/8  head strobes.
- m_tlast  output  1  head end of packet.
- level  output  $clog2(FIFO_DEPTH)+1  number of stored beats, 0..FIFO_DEPTH.

Behaviour:
- Clock and reset: one clock, aclk. Reset areset is asynchronous and active-high.
- While areset is high:
  - write pointer, read pointer and level = 0.
  - m_tvalid = 0, s_tready = 0.
  - Storage array is not reset; m_tdata/m_tstrb/m_tlast are don't-care while m_tvalid = 0.
- First rising aclk after areset falls: s_tready = 1.
- Push: s_tvalid && s_tready at a rising edge writes {tdata, tstrb, tlast} to mem[wr_ptr]; wr_ptr increments.
- Pop: m_tvalid && m_tready at a rising edge; rd_ptr increments.
- Pointers: $clog2(FIFO_DEPTH)+1 bits. Wrap naturally modulo 2*FIFO_DEPTH; index with the low bits.
  - full when the low bits are equal and the MSBs differ.
  - empty when the pointers are equal.
- s_tready = !full, registered/derived from registered pointers; no combinational path from m_tready to s_tready.
- m_tvalid = !empty. m_tdata/m_tstrb/m_tlast = mem[rd_ptr] (first-word fall-through).
- Latency: a beat pushed at edge N is presented on m_* with m_tvalid = 1 in the cycle after edge N. Minimum 1 cycle when empty.
- level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Boundary cases:
  - Full with m_tready = 1: the pop at edge N frees an entry; s_tready = 1 after edge N. No same-cycle push-on-pop when full.
  - Empty with s_tvalid = 1: no pop possible; beat appears next cycle. No combinational bypass.
  - Simultaneous push and pop at level 1..FIFO_DEPTH-1: both occur; level unchanged.
- m_* stability: m_* held stable while m_tvalid && !m_tready (AXIS rule); the head entry is never overwritten.
- Data integrity: tlast and tstrb travel with their beat unmodified; no reordering, no drop, no duplication.
- Reset mid-operation: all stored beats discarded; m_tvalid falls asynchronously; level = 0.

Optional Feature:
- Macro: AXIS_FIFO_PKT_MODE_EN.
- Defined (packet mode):
  - Adds a packet counter, width $clog2(FIFO_DEPTH)+1:
    - +1 on a push with s_tlast = 1.
    - -1 on a pop with m_tlast = 1.
    - unchanged if both occur in the same cycle.
  - m_tvalid = !empty && (pkt_count != 0 || full).
  - The full term releases packets longer than FIFO_DEPTH to avoid deadlock.
  - Counter resets to 0 with areset.
- Undefined: the packet counter is not built; m_tvalid = !empty.

Test Plan:
- Reset then single beat: push tdata=0xA5A5_0001, tstrb=0xF, tlast=1 at edge N, m_tready=1 -> m_tvalid=1 from cycle N+1 with the same values; level 1 then 0; s_tready=1 throughout.
- Fill: m_tready=0, push 16 beats 0x0..0xF -> level=16, s_tready=0 after the 16th edge; a 17th s_tvalid is not accepted; m_tdata=0x0.
- Drain while full: raise m_tready for 1 cycle -> pop 0x0, s_tready=1 next cycle, level=15; continue draining -> output order 0x1..0xF, last m_tlast as written.
- Streaming: s_tvalid=m_tready=1 continuously for 100 beats, incrementing data -> level constant at 1 after fill, one beat per cycle, no gaps, no loss.
- Async reset mid-stream: assert areset between edges with level=5 -> m_tvalid=0 and level=0 immediately; s_tready=0 until the first edge after release.
- AXIS_FIFO_PKT_MODE_EN, partial packet: push 3 beats with tlast=0 -> m_tvalid stays 0. Push a 4th beat with tlast=1 -> m_tvalid=1 the next cycle; 4 beats drain.
- AXIS_FIFO_PKT_MODE_EN, oversize packet: push 20 beats without tlast -> m_tvalid=1 once full, so no deadlock.

Source files
------------

// File: rtl/axis_fifo_sync.sv
// ============================================================================
// axis_fifo_sync -- single-clock AXI4-Stream FIFO, first-word fall-through.
// Optional packet mode: `define AXIS_FIFO_PKT_MODE_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_fifo_sync #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                s_tvalid,
  output logic                                s_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]          s_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]        s_tstrb,
  input  logic                                s_tlast,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [AXIS_DATA_WIDTH-1:0]          m_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]        m_tstrb,
  output logic                                m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]         level
);

  localparam int STRB_W  = AXIS_DATA_WIDTH / 8;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = AXIS_DATA_WIDTH + STRB_W + 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                ready_en;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // ready_en keeps s_tready low until the first edge after reset release.
  assign s_tready = ready_en && !full;
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  assign head = mem[rd_ptr[AW-1:0]];
  assign {m_tdata, m_tstrb, m_tlast} = head;

  assign level = wr_ptr - rd_ptr;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is not reset; contents are only observed while m_tvalid is high.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s_tdata, s_tstrb, s_tlast};
  end

`ifdef AXIS_FIFO_PKT_MODE_EN
  logic [AW:0] pkt_count;
  logic        pkt_inc;
  logic        pkt_dec;

  assign pkt_inc = push && s_tlast;
  assign pkt_dec = pop && m_tlast;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_count <= '0;
    end else if (pkt_inc && !pkt_dec) begin
      pkt_count <= pkt_count + PTR_ONE;
    end else if (pkt_dec && !pkt_inc) begin
      pkt_count <= pkt_count - PTR_ONE;
    end
  end

  // The full term releases packets longer than the FIFO so they cannot deadlock.
  assign m_tvalid = !empty && ((pkt_count != '0) || full);
`else
  assign m_tvalid = !empty;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_fifo_sync.sv
// ============================================================================
// tb_axis_fifo_sync -- directed self-checking bench for axis_fifo_sync.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis_fifo_sync;

  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          aclk;
  logic          areset;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic          m_tlast;
  logic [LW-1:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  axis_fifo_sync #(
    .AXIS_DATA_WIDTH (DW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tstrb  (s_tstrb),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tstrb  (m_tstrb),
    .m_tlast  (m_tlast),
    .level    (level)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tstrb  = s;
    s_tlast  = l;
  endtask

  initial begin
    areset   = 1'b1;
    m_tready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    // Reset state
    #2;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_level",    64'(level),    64'd0);
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    #1;
    check("rel_s_tready_before_edge", 64'(s_tready), 64'd0);
    step();
    check("rel_s_tready_after_edge", 64'(s_tready), 64'd1);

    // Single beat, one-cycle fall-through latency
    m_tready = 1'b1;
    drive(1'b1, 32'hA5A5_0001, 4'hF, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    check("single_m_tvalid", 64'(m_tvalid), 64'd1);
    check("single_m_tdata",  64'(m_tdata),  64'hA5A5_0001);
    check("single_m_tstrb",  64'(m_tstrb),  64'hF);
    check("single_m_tlast",  64'(m_tlast),  64'd1);
    check("single_level1",   64'(level),    64'd1);
    check("single_s_tready", 64'(s_tready), 64'd1);
    step();
    check("single_level0",   64'(level),    64'd0);
    check("single_empty",    64'(m_tvalid), 64'd0);

    // Fill to DEPTH with the consumer stalled
    m_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, DW'(i), SW'(i), (i == DEPTH - 1));
      step();
    end
    check("fill_level",    64'(level),    64'd16);
    check("fill_s_tready", 64'(s_tready), 64'd0);
    check("fill_m_tvalid", 64'(m_tvalid), 64'd1);
    check("fill_m_tdata",  64'(m_tdata),  64'h0);
    drive(1'b1, 32'hDEAD_0017, 4'h3, 1'b0);
    step();
    check("fill_17th_rejected", 64'(level), 64'd16);

    // Pop while full with upstream still valid: no push on the freeing edge
    drive(1'b1, 32'hBEEF_0000, 4'h1, 1'b0);
    m_tready = 1'b1;
    step();
    drive(1'b0, '0, '0, 1'b0);
    check("drain_level15",   64'(level),    64'd15);
    check("drain_s_tready",  64'(s_tready), 64'd1);
    for (int i = 1; i < DEPTH; i++) begin
      check($sformatf("drain_valid_%0d", i), 64'(m_tvalid), 64'd1);
      check($sformatf("drain_data_%0d", i),  64'(m_tdata),  64'(i));
      check($sformatf("drain_strb_%0d", i),  64'(m_tstrb),  64'(i % 16));
      check($sformatf("drain_last_%0d", i),  64'(m_tlast),  64'(i == DEPTH - 1));
      step();
    end
    check("drain_empty_level", 64'(level),    64'd0);
    check("drain_empty_valid", 64'(m_tvalid), 64'd0);

    // Continuous streaming: one beat per cycle, level stays at 1
    m_tready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, 32'h0000_1000 + DW'(k), SW'(k), 1'b1);
      step();
      check($sformatf("stream_valid_%0d", k), 64'(m_tvalid), 64'd1);
      check($sformatf("stream_data_%0d", k),  64'(m_tdata),  64'h1000 + 64'(k));
      check($sformatf("stream_level_%0d", k), 64'(level),    64'd1);
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("stream_end_level", 64'(level),    64'd0);
    check("stream_end_valid", 64'(m_tvalid), 64'd0);

    // Asynchronous reset between edges with five beats stored
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0000_2000 + DW'(i), 4'hF, 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("arst_pre_level", 64'(level), 64'd5);
    #2 areset = 1'b1;
    #1;
    check("arst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("arst_level",    64'(level),    64'd0);
    check("arst_s_tready", 64'(s_tready), 64'd0);
    step();
    areset = 1'b0;
    #1;
    check("arst_rel_s_tready_low", 64'(s_tready), 64'd0);
    step();
    check("arst_rel_s_tready_high", 64'(s_tready), 64'd1);
    check("arst_rel_m_tvalid",      64'(m_tvalid), 64'd0);

`ifdef AXIS_FIFO_PKT_MODE_EN
    // Partial packet is held back until its tlast beat arrives
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0000_3000 + DW'(i), 4'hF, 1'b0);
      step();
      check($sformatf("pkt_partial_hold_%0d", i), 64'(m_tvalid), 64'd0);
    end
    drive(1'b1, 32'h0000_3003, 4'hF, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    check("pkt_release_valid", 64'(m_tvalid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pkt_drain_data_%0d", i), 64'(m_tdata), 64'h3000 + 64'(i));
      check($sformatf("pkt_drain_last_%0d", i), 64'(m_tlast), 64'(i == 3));
      step();
    end
    check("pkt_drain_empty", 64'(m_tvalid), 64'd0);

    // Oversize packet is released once the FIFO fills
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h0000_4000 + DW'(i), 4'hF, 1'b0);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    check("pkt_oversize_level", 64'(level),    64'd16);
    check("pkt_oversize_valid", 64'(m_tvalid), 64'd1);
    check("pkt_oversize_data",  64'(m_tdata),  64'h4000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
